// File: rtl/counter.sv
// Up/down counter with synchronous parallel load and a synchronous high-active reset.
// Priority on each rising edge: reset, then load, then inc/dec, then hold.
module counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             inc,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  input  logic             dec
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] w_next;

  // inc and dec together cancel out, so only a lone enable moves the count.
  always_comb begin
    w_next = r_count;
    if (load) begin
      w_next = d;
    end else if (inc && !dec) begin
      w_next = r_count + ONE;
    end else if (dec && !inc) begin
      w_next = r_count - ONE;
    end
  end

  // Despite its name, rst_n is high-active.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_count <= '0;
    end else begin
      r_count <= w_next;
    end
  end

  assign q = r_count;

endmodule

// File: tb/tb_counter.sv
// Scoreboard bench for counter (WIDTH=8).
// The driver queues a hand-computed expected q per cycle, and a monitor pops and compares it after each edge.
module tb_counter;

  localparam int WIDTH = 8;

  typedef struct {
    logic             check;
    logic [WIDTH-1:0] value;
    string            name;
  } expect_t;

  logic             clk;
  logic             rst_n;
  logic             load;
  logic             inc;
  logic             dec;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] q;

  expect_t sbQueue[$];
  int      numCompared;
  int      numMismatched;

  counter #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load),
    .inc   (inc),
    .d     (d),
    .q     (q),
    .dec   (dec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [WIDTH-1:0] actual,
                             input logic [WIDTH-1:0] required);
    numCompared++;
    if (actual !== required) begin
      numMismatched++;
      $display("[TB] FAIL %s: q=%0d required=%0d", name, actual, required);
    end
  endtask

  // Inputs change on the falling edge; glitch pulses rst_n high between edges and drops it again before the rising edge.
  task automatic applyStimulus(input logic rst, input logic ld, input logic up, input logic down,
                               input logic [WIDTH-1:0] data, input logic glitch,
                               input logic [WIDTH-1:0] expQ, input string name);
    expect_t e;
    @(negedge clk);
    rst_n = rst;
    load  = ld;
    inc   = up;
    dec   = down;
    d     = data;
    e.check = 1'b1;
    e.value = expQ;
    e.name  = name;
    sbQueue.push_back(e);
    if (glitch) begin
      #1 rst_n = 1'b1;
      #2 rst_n = 1'b0;
    end
  endtask

  // Monitor: every rising edge produces a new q, so one expectation is consumed per edge.
  initial begin
    expect_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sbQueue.size() > 0) begin
        e = sbQueue.pop_front();
        if (e.check) checkOutput(e.name, q, e.value);
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int waitCycles;
    numCompared   = 0;
    numMismatched = 0;
    rst_n = 1'b0;
    load  = 1'b0;
    inc   = 1'b0;
    dec   = 1'b0;
    d     = '0;
    @(posedge clk);

    applyStimulus(1, 0, 0, 0, 8'd0,   0, 8'd0,   "reset");
    applyStimulus(0, 0, 1, 0, 8'd0,   0, 8'd1,   "inc1");
    applyStimulus(0, 0, 1, 0, 8'd0,   0, 8'd2,   "inc2");
    applyStimulus(0, 0, 1, 0, 8'd0,   0, 8'd3,   "inc3");
    applyStimulus(0, 1, 0, 0, 8'd123, 0, 8'd123, "load123");
    applyStimulus(0, 0, 0, 1, 8'd0,   0, 8'd122, "dec1");
    applyStimulus(0, 0, 0, 1, 8'd0,   0, 8'd121, "dec2");
    applyStimulus(0, 0, 0, 1, 8'd0,   0, 8'd120, "dec3");
    applyStimulus(0, 1, 0, 1, 8'd254, 0, 8'd254, "loadBeatsDec");
    applyStimulus(0, 0, 1, 0, 8'd0,   0, 8'd255, "incTo255");
    applyStimulus(0, 0, 1, 0, 8'd0,   0, 8'd0,   "overflowWrap");
    applyStimulus(0, 0, 1, 0, 8'd0,   0, 8'd1,   "incAfterWrap");
    applyStimulus(1, 0, 0, 0, 8'd0,   0, 8'd0,   "resetAgain");
    applyStimulus(0, 0, 0, 1, 8'd0,   0, 8'd255, "underflowWrap");
    applyStimulus(0, 0, 1, 1, 8'd0,   0, 8'd255, "incDecHold");
    applyStimulus(0, 0, 0, 0, 8'd0,   0, 8'd255, "idleHold");
    applyStimulus(0, 0, 0, 0, 8'd0,   1, 8'd255, "midCycleReset");
    applyStimulus(0, 0, 1, 0, 8'd0,   0, 8'd0,   "incWrapAgain");
    applyStimulus(0, 0, 1, 0, 8'd0,   0, 8'd1,   "countA");
    applyStimulus(0, 0, 1, 0, 8'd0,   0, 8'd2,   "countB");
    applyStimulus(1, 0, 1, 0, 8'd0,   0, 8'd0,   "resetMidCount");
    applyStimulus(0, 0, 1, 0, 8'd0,   0, 8'd1,   "resumeFromZero");
    applyStimulus(0, 1, 1, 1, 8'd7,   0, 8'd7,   "loadBeatsBoth");
    applyStimulus(0, 0, 0, 1, 8'd0,   0, 8'd6,   "decFrom7");
    applyStimulus(1, 1, 1, 0, 8'd99,  0, 8'd0,   "resetBeatsLoad");
    applyStimulus(0, 0, 0, 0, 8'd0,   0, 8'd0,   "holdZero");

    waitCycles = 0;
    while (sbQueue.size() > 0 && waitCycles < 20) begin
      @(posedge clk);
      waitCycles++;
    end
    @(negedge clk);
    if (sbQueue.size() > 0) begin
      numCompared++;
      numMismatched++;
      $display("[TB] FAIL drain: %0d expectations left, required 0", sbQueue.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
    $finish;
  end

endmodule

// File: doc/counter.md
COUNTER -- requirements
Module: counter

Interface
REQ-001 Parameter: WIDTH, default 8, counter and data width in bits; SHALL support any WIDTH >= 1.
REQ-002 clk  input  1  sole clock; all state SHALL update on rising edge only.
REQ-003 rst_n  input  1  synchronous, active-high reset; the name rst_n SHALL be kept, polarity is high-active.
REQ-004 load  input  1  parallel-load enable.
REQ-005 inc  input  1  count-up enable.
REQ-006 d  input  WIDTH  parallel-load data.
REQ-007 q  output  WIDTH  current count, driven directly from the count register.
REQ-008 dec  input  1  count-down enable.
REQ-009 Positional port order SHALL be: clk, rst_n, load, inc, d, q, dec.

Function
REQ-010 q SHALL change only on a rising clk edge; no combinational path from any input to q.
REQ-011 Per-edge priority SHALL be: rst_n, then load, then inc/dec, then hold.
REQ-012 rst_n=1: q SHALL become 0 next edge, regardless of load/inc/dec/d.
REQ-013 rst_n=0, load=1: q SHALL become d next edge; inc and dec ignored.
REQ-014 rst_n=0, load=0, inc=1, dec=0: q SHALL become q+1 mod 2^WIDTH.
REQ-015 rst_n=0, load=0, inc=0, dec=1: q SHALL become q-1 mod 2^WIDTH.
REQ-016 rst_n=0, load=0, inc=1, dec=1: q SHALL hold (net zero change).
REQ-017 All enables low: q SHALL hold.
REQ-018 Overflow: q=2^WIDTH-1 with increment SHALL wrap to 0; no carry/flag output.
REQ-019 Underflow: q=0 with decrement SHALL wrap to 2^WIDTH-1; no borrow/flag output.
REQ-020 Latency SHALL be exactly one clock from sampled inputs to updated q; enables act every cycle they are held (level-sensitive, not edge-detected).

Reset
REQ-021 Reset value of q SHALL be 0.
REQ-022 Reset SHALL be sampled only at the rising clk edge; asserting rst_n between edges SHALL NOT change q.
REQ-023 Reset asserted mid-count (inc or dec active) SHALL force q=0 at that edge; counting SHALL resume from 0 on the first edge after rst_n deasserts.
REQ-024 Before the first reset edge q is undefined; the bench SHALL NOT check q until after one reset edge.

Verification (WIDTH=8)
REQ-025 rst_n=1 one edge, all enables 0 -> q=0.
REQ-026 From q=0, inc=1 three edges -> q=1,2,3.
REQ-027 load=1, d=123, inc=0 -> q=123; then dec=1, load=0 three edges -> q=122,121,120.
REQ-028 load=1, d=254, dec=1 simultaneously -> q=254 (load wins); then inc=1 three edges -> q=255,0,1 (wrap).
REQ-029 q=0, dec=1 one edge -> q=255; inc=1 and dec=1 together -> q holds 255.
REQ-030 inc=1 counting, rst_n=1 one edge -> q=0; rst_n=0 with inc=1 next edge -> q=1.
